// File: rtl/wb_ahb_pkg.sv
// Shared types and constants for the Wishbone-to-AHB-Lite bridge.
// The ST_DRAIN state exists only when WB_AHB_TIMEOUT_EN is defined.
package wb_ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ACK
`ifdef WB_AHB_TIMEOUT_EN
    , ST_DRAIN
`endif
  } state_e;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0]  HSIZE_BYTE    = 3'b000;
  localparam logic [2:0]  HSIZE_HALF    = 3'b001;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;

  localparam logic [2:0]  HBURST_SINGLE = 3'b000;

  localparam logic [31:0] ERR_DATA      = 32'hBAD0_0BAD;
  localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_0001;

  function automatic logic window_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_ahb_size_decode.sv
// Maps Wishbone byte selects to an AHB transfer size and low address bits;
// any pattern that is not a word, aligned halfword or single byte is illegal.
module wb_ahb_size_decode
  import wb_ahb_pkg::*;
(
  input  logic [3:0] sel,
  output logic       legal,
  output logic [2:0] hsize,
  output logic [1:0] addr_lo
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    legal   = 1'b1;
    hsize   = HSIZE_WORD;
    addr_lo = 2'b00;
    case (sel)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
      4'b0001: hsize = HSIZE_BYTE;
      4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
      4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
      4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_ahb_bridge.sv
// Wishbone-classic slave to AHB-Lite master: one SINGLE transfer per Wishbone cycle.
// Define WB_AHB_TIMEOUT_EN to bound the AHB data phase and add the DRAIN state.
module wb_ahb_bridge
  import wb_ahb_pkg::*;
#(
  parameter logic [31:0] WB_BASE        = 32'h3000_0000,
  parameter logic [31:0] WB_MASK        = 32'hFFF0_0000,
  parameter logic [31:0] AHB_BASE       = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state;
  logic        legal;
  logic [2:0]  dec_size;
  logic [1:0]  dec_lo;
  logic        hit;
  logic [31:2] ahb_word;
  logic [31:0] wdata_q;

  wb_ahb_size_decode u_size_decode (
    .sel     (wbs_sel_i),
    .legal   (legal),
    .hsize   (dec_size),
    .addr_lo (dec_lo)
  );

  assign hit      = window_hit(wbs_adr_i, WB_BASE, WB_MASK);
  assign ahb_word = AHB_BASE[31:2] | (wbs_adr_i[31:2] & ~WB_MASK[31:2]);
  assign HBURST   = HBURST_SINGLE;

`ifdef WB_AHB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;
`endif

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      bus_err_o <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_WORD;
      HWDATA    <= '0;
      wdata_q   <= '0;
`ifdef WB_AHB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      // Ack and error are single-cycle pulses unless a branch below raises them.
      wbs_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wbs_stb_i && wbs_cyc_i) begin
            if (!hit || !legal) begin
              state     <= ST_ACK;
              wbs_ack_o <= 1'b1;
              bus_err_o <= 1'b1;
              wbs_dat_o <= '0;
            end else begin
              state   <= ST_ADDR;
              HTRANS  <= HTRANS_NONSEQ;
              HADDR   <= {ahb_word, dec_lo};
              HWRITE  <= wbs_we_i;
              HSIZE   <= dec_size;
              wdata_q <= wbs_dat_i;
            end
          end
        end

        ST_ADDR: begin
          if (HREADY) begin
            state  <= ST_DATA;
            HTRANS <= HTRANS_IDLE;
            HWDATA <= wdata_q;
`ifdef WB_AHB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end

        ST_DATA: begin
          // An error is taken on its first cycle, before the slave raises HREADY.
          if (HRESP) begin
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            bus_err_o <= 1'b1;
            wbs_dat_o <= ERR_DATA;
          end else if (HREADY) begin
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= HWRITE ? '0 : HRDATA;
          end
`ifdef WB_AHB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_DRAIN;
            wbs_ack_o <= 1'b1;
            bus_err_o <= 1'b1;
            wbs_dat_o <= TIMEOUT_DATA;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        ST_ACK: state <= ST_IDLE;

`ifdef WB_AHB_TIMEOUT_EN
        // The abandoned data phase must finish before a new address phase starts.
        ST_DRAIN: begin
          if (HREADY) state <= ST_IDLE;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Scoreboard bench for wb_ahb_bridge: driver pushes expected acks and AHB
// address phases, independent monitors pop and compare on each DUT event.
module tb_wb_ahb_bridge;
  import wb_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;
  logic        bus_err_o;

  wb_ahb_bridge dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          lat;       // ack cycle relative to the sampling edge (N+lat)
    bit          ahb;       // an AHB address phase is expected
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    int          waits;     // HREADY-low cycles in the data phase
    bit          err;       // slave answers with an ERROR response
    logic [31:0] rdata;
    int          ack_at;    // absolute ack cycle override when nonzero
  } txn_t;

  typedef struct { logic [31:0] dat; logic err; int cyc; } ack_exp_t;
  typedef struct { logic [31:0] haddr; logic [2:0] hsize; logic hwrite; logic [31:0] hwdata; } ahb_exp_t;

  ack_exp_t ack_q[$];
  ahb_exp_t ahb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int last_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  // AHB slave model: per-transfer wait states / error latched at address acceptance.
  int          cur_waits = 0;
  bit          cur_err   = 1'b0;
  logic [31:0] cur_rdata = '0;
  bit          dphase = 1'b0;
  int          wcnt = 0, s_waits = 0;
  bit          s_err = 1'b0;
  logic [31:0] s_rdata = '0;

  always @(posedge clk) begin
    if (rst) dphase = 1'b0;
    else if (HREADY && HTRANS == HTRANS_NONSEQ) begin
      dphase = 1'b1; wcnt = 0;
      s_waits = cur_waits; s_err = cur_err; s_rdata = cur_rdata;
    end else if (dphase && HREADY) dphase = 1'b0;
    #1;
    if (dphase && wcnt < s_waits) begin
      HREADY = 1'b0; HRESP = s_err; HRDATA = s_rdata; wcnt++;
    end else if (dphase) begin
      HREADY = 1'b1; HRESP = s_err; HRDATA = s_rdata;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
    end
  end

  // Monitors: sample on the falling edge, away from DUT updates.
  bit          wd_pend = 1'b0;
  logic [31:0] wd_exp  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wd_pend) begin
        check("hwdata", HWDATA, wd_exp);
        wd_pend = 1'b0;
      end
      if (HTRANS == HTRANS_NONSEQ && HREADY) begin
        if (ahb_q.size() == 0) check("unexpected_nonseq", HTRANS, HTRANS_IDLE);
        else begin
          ahb_exp_t a;
          a = ahb_q.pop_front();
          check("haddr",  HADDR,  a.haddr);
          check("hsize",  HSIZE,  a.hsize);
          check("hwrite", HWRITE, a.hwrite);
          check("hburst", HBURST, HBURST_SINGLE);
          if (a.hwrite) begin wd_pend = 1'b1; wd_exp = a.hwdata; end
        end
      end
      if (wbs_ack_o) begin
        if (ack_q.size() == 0) check("unexpected_ack", wbs_ack_o, 1'b0);
        else begin
          ack_exp_t e;
          e = ack_q.pop_front();
          check("ack_cycle", cyc_cnt,   e.cyc);
          check("rdata",     wbs_dat_o, e.dat);
          check("bus_err",   bus_err_o, e.err);
        end
      end else if (bus_err_o) begin
        check("bus_err_without_ack", bus_err_o, 1'b0);
      end
    end
  end

  task automatic wb_xfer(input txn_t t);
    int n_edge;
    bit got;
    cur_waits = t.waits; cur_err = t.err; cur_rdata = t.rdata;
    n_edge = cyc_cnt + 1;
    last_n = n_edge;
    ack_q.push_back('{dat: t.exp_dat, err: t.exp_err,
                      cyc: (t.ack_at != 0) ? t.ack_at : n_edge + t.lat - 1});
    if (t.ahb)
      ahb_q.push_back('{haddr: t.exp_haddr, hsize: t.exp_hsize, hwrite: t.we, hwdata: t.wdata});
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = t.we;
    wbs_adr_i = t.adr; wbs_sel_i = t.sel; wbs_dat_i = t.wdata;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    check("ack_seen", got, 1'b1);
    // Strobe stays high across the ack cycle to show it is not re-issued.
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},    wbs_ack_o, 1'b0);
    check({tag, "_dat"},    wbs_dat_o, 32'h0);
    check({tag, "_htrans"}, HTRANS,    HTRANS_IDLE);
    check({tag, "_haddr"},  HADDR,     32'h0);
    check({tag, "_hwrite"}, HWRITE,    1'b0);
    check({tag, "_hsize"},  HSIZE,     3'b010);
    check({tag, "_hburst"}, HBURST,    3'b000);
    check({tag, "_hwdata"}, HWDATA,    32'h0);
    check({tag, "_buserr"}, bus_err_o, 1'b0);
  endtask

  // Directed vectors: we adr sel wdata exp_dat exp_err lat ahb haddr hsize waits err rdata ack_at
  txn_t vec[10];
  initial begin
    vec[0] = '{1'b1, 32'h3000_0010, 4'b1111, 32'h1234_5678, 32'h0,          1'b0, 3, 1'b1, 32'h8000_0010, 3'b010, 0, 1'b0, 32'h0,          0};
    vec[1] = '{1'b0, 32'h3000_0004, 4'b0100, 32'h0,          32'h00AB_0000, 1'b0, 5, 1'b1, 32'h8000_0006, 3'b000, 2, 1'b0, 32'h00AB_0000, 0};
    vec[2] = '{1'b1, 32'h3000_0100, 4'b1100, 32'hBEEF_0000, 32'h0,          1'b0, 3, 1'b1, 32'h8000_0102, 3'b001, 0, 1'b0, 32'h0,          0};
    vec[3] = '{1'b0, 32'h300A_BCD0, 4'b1111, 32'h0,          32'hCAFE_F00D, 1'b0, 3, 1'b1, 32'h800A_BCD0, 3'b010, 0, 1'b0, 32'hCAFE_F00D, 0};
    vec[4] = '{1'b1, 32'h3000_0008, 4'b0001, 32'h0000_00EE, 32'h0,          1'b0, 4, 1'b1, 32'h8000_0008, 3'b000, 1, 1'b0, 32'h0,          0};
    vec[5] = '{1'b0, 32'h300F_FFFC, 4'b1000, 32'h0,          32'h7700_0000, 1'b0, 3, 1'b1, 32'h800F_FFFF, 3'b000, 0, 1'b0, 32'h7700_0000, 0};
    vec[6] = '{1'b0, 32'h3000_0030, 4'b1111, 32'h0,          32'hBAD0_0BAD, 1'b1, 3, 1'b1, 32'h8000_0030, 3'b010, 1, 1'b1, 32'h1111_2222, 0};
    vec[7] = '{1'b0, 32'h2000_0000, 4'b1111, 32'h0,          32'h0,          1'b1, 1, 1'b0, 32'h0,          3'b010, 0, 1'b0, 32'h0,          0};
    vec[8] = '{1'b0, 32'h3000_0000, 4'b0110, 32'h0,          32'h0,          1'b1, 1, 1'b0, 32'h0,          3'b010, 0, 1'b0, 32'h0,          0};
    vec[9] = '{1'b1, 32'h3FF0_0000, 4'b0011, 32'hAAAA_5555, 32'h0,          1'b1, 1, 1'b0, 32'h0,          3'b001, 0, 1'b0, 32'h0,          0};
  end

  initial begin
    txn_t t;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      wb_xfer(vec[i]);
      @(negedge clk);
    end

`ifdef WB_AHB_TIMEOUT_EN
    // Stalled data phase: timeout ack, then a queued request waits for HREADY.
    t = '{1'b0, 32'h3000_0040, 4'b1111, 32'h0, 32'hDEAD_0001, 1'b1, 258, 1'b1,
          32'h8000_0040, 3'b010, 300, 1'b0, 32'h0, 0};
    wb_xfer(t);
    t = '{1'b0, 32'h3000_0044, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0, 3, 1'b1,
          32'h8000_0044, 3'b010, 0, 1'b0, 32'h55AA_55AA, last_n + 305};
    wb_xfer(t);
    @(negedge clk);
`endif

    // Reset in the middle of a stalled write data phase.
    cur_waits = 10; cur_err = 1'b0; cur_rdata = '0;
    ahb_q.push_back('{haddr: 32'h8000_0020, hsize: 3'b010, hwrite: 1'b1, hwdata: 32'h0F0F_F0F0});
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0020; wbs_sel_i = 4'b1111; wbs_dat_i = 32'h0F0F_F0F0;
    repeat (4) @(negedge clk);
    check("pre_reset_hwrite", HWRITE, 1'b1);
    rst = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b0;

    repeat (5) @(negedge clk);
    check("ack_queue_empty", ack_q.size(), 32'd0);
    check("ahb_queue_empty", ahb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
